jk_cmd_sequencer: RTL
=====================

// Module: jk_cmd_sequencer
//
// PURPOSE
//   Upstream stimulus stage for jk_flipflop_simple: accepts JK commands
//   (hold/reset/set/toggle + repeat count) over a valid/ready handshake,
//   buffers them in a small FIFO, and drives registered j/k outputs for
//   the requested number of clock cycles, back-to-back with no bubbles.
//   Outputs j/k connect directly to the flip-flop's j/k inputs.
//
// PARAMETERS
//   DEPTH  4  command FIFO entries; power of 2, >= 2
//   CNT_W  8  width of the per-command repeat count
//
// PORTS
//   clock       in   1               rising-edge clock
//   reset       in   1               asynchronous, active-high reset
//   cmd_valid   in   1               command present on cmd_op/cmd_count
//   cmd_ready   out  1               FIFO can accept; = !full (combinational)
//   cmd_op      in   2               00 hold, 01 reset(j0k1), 10 set(j1k0), 11 toggle(j1k1)
//   cmd_count   in   CNT_W           cycles to drive op; 0 treated as 1
//   j           out  1               registered J drive
//   k           out  1               registered K drive
//   busy        out  1               1 while in DRIVE
//   done        out  1               1 during final drive cycle of each command
//   fifo_level  out  $clog2(DEPTH)+1 entries currently buffered
//
// BEHAVIOUR
//   Reset (async, immediate): FIFO cleared (level 0), state IDLE, j=k=0,
//     busy=0, done=0, remaining=0; cmd_ready=1. Reset mid-command aborts
//     it and discards all buffered commands.
//   Push: on edge with cmd_valid && cmd_ready, {cmd_op,cmd_count} written.
//     cmd_valid while full is ignored; requester holds it (no drop).
//   Push + pop same edge: allowed when not full; level unchanged.
//     No bypass: a command into an empty FIFO is popped one edge later.
//   FSM states: IDLE, DRIVE.
//   IDLE: j=k=0. If FIFO non-empty at edge: pop head, j/k <= decode(op),
//     remaining <= (count==0 ? 1 : count), -> DRIVE.
//   DRIVE: j/k held. At each edge:
//     remaining>1 : remaining <= remaining-1.
//     remaining==1: if FIFO non-empty, pop and load next op/count (stay
//       DRIVE, zero gap); else j=k=0, remaining 0, -> IDLE.
//   Latency: cmd accepted at edge E0 into idle/empty -> j/k valid after
//     E1, held for N full cycles, returns 0 after E(1+N).
//   busy = (state==DRIVE); done = busy && (remaining==1) (comb. from regs).
//   Op 00 (hold) still occupies N cycles with j=k=0 and busy=1.
//   Pointers wrap modulo DEPTH; level never exceeds DEPTH nor underflows.
//
// TESTING
//   1 Reset pulse mid-DRIVE with level=3 -> j=k=0, busy=0, level=0,
//     cmd_ready=1 without waiting for a clock edge; no later j/k activity.
//   2 Idle, push op=10 count=3 -> j=1,k=0 for exactly 3 cycles starting
//     after the next edge, done=1 in 3rd cycle only, then j=k=0, busy=0.
//   3 Push 11/2 then 01/1 on consecutive cycles -> j=k=1 for 2 cycles then
//     j=0,k=1 for 1 cycle, no idle gap; done=1 in cycles 2 and 3.
//   4 Push op=11 count=0 -> j=k=1 for exactly 1 cycle, done=1 that cycle.
//   5 During op=00 count=255, push 5 commands -> cmd_ready=0 after 4th,
//     level=4, 5th held and accepted on the edge after first pop.
//   6 Drive jk_flipflop_simple: 10/1 then 11/3 -> q=1 after set, then
//     toggles 3 times, final q=0, qbar=1.

Source files
------------

// File: rtl/jk_cmd_sequencer.sv
// Command sequencer for a JK flip-flop: buffers {op,count} commands in a small
// FIFO and drives registered j/k for count cycles each, back-to-back.
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [CNT_W-1:0]         cmd_count,
  output logic                     j,
  output logic                     k,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  // state    | meaning
  // ST_IDLE  | nothing driving, j=k=0, waiting for a buffered command
  // ST_DRIVE | holding j/k of the current command for `remaining` cycles
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]    LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]    LVL_ONE  = (AW+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [0:0]        state;
  logic [CNT_W-1:0]  remaining;

  logic [CNT_W+1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       level;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              last_beat;
  logic [CNT_W+1:0]  head;
  logic [1:0]        head_op;
  logic [CNT_W-1:0]  head_cnt;
  logic [CNT_W-1:0]  load_cnt;

  assign full      = (level == LVL_FULL);
  assign empty     = (level == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;

  assign last_beat = (state == ST_DRIVE) && (remaining == CNT_ONE);
  // Pop only when the output stage is free now or frees at this edge.
  assign pop       = !empty && ((state == ST_IDLE) || last_beat);

  assign head      = mem[rd_ptr];
  assign head_op   = head[CNT_W+1:CNT_W];
  assign head_cnt  = head[CNT_W-1:0];
  assign load_cnt  = (head_cnt == '0) ? CNT_ONE : head_cnt;

  assign busy       = (state == ST_DRIVE);
  assign done       = busy && (remaining == CNT_ONE);
  assign fifo_level = level;

  // Storage is not reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_op, cmd_count};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      j         <= 1'b0;
      k         <= 1'b0;
      remaining <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            {j, k}    <= head_op;
            remaining <= load_cnt;
            state     <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (remaining > CNT_ONE) begin
            remaining <= remaining - CNT_ONE;
          end else if (pop) begin
            {j, k}    <= head_op;
            remaining <= load_cnt;
          end else begin
            j         <= 1'b0;
            k         <= 1'b0;
            remaining <= '0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          j         <= 1'b0;
          k         <= 1'b0;
          remaining <= '0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
